click_sync_sink: RTL and testbench

Clocked receiving end of the click-pipeline drive/free handshake. Takes 2-phase tokens from the last stage of a click FIFO (its `driveNext` toggle plus bundled data), synchronizes them into the `clk` domain, stores the words in a small FIFO, and returns the `free` toggle to the pipeline. Words leave on a valid/ready interface. This is the point where asynchronous pipeline output enters synchronous logic.

---
 rtl/click_sync_sink.sv | 132 +++++++++++++
 tb/tb_click_sync_sink.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/click_sync_sink.sv
`timescale 1ns/1ps
// click_sync_sink: receiving end of a 2-phase drive/free click pipeline.
// Synchronizes the drive toggle into clk, buffers bundled data in a small
// FWFT FIFO, and returns the free toggle. The ack is withheld when the
// buffer fills and released on the next pop.
module click_sync_sink #(
  parameter int DW          = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_drive,
  input  logic [DW-1:0]          i_data,
  output logic                   o_free,
  output logic                   o_valid,
  output logic [DW-1:0]          o_data,
  input  logic                   i_ready,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  logic [SYNC_STAGES-1:0]    sync_q;
  logic                      seen_q, seen_d;
  logic                      free_q, free_d;
  state_e                    state_q, state_d;
  logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             count_q, count_d;
  logic [DEPTH-1:0][DW-1:0]  mem_q;

  logic                      drive_s;
  logic                      pending;
  logic                      pop;
  logic                      wr;
  logic [CW-1:0]             cnt_post;

  assign drive_s = sync_q[SYNC_STAGES-1];
  assign pending = drive_s ^ seen_q;
  assign pop     = o_valid & i_ready;
  // A well-behaved upstream never sends into a full buffer; the guard keeps
  // a misbehaving one from corrupting occupancy (the token stays pending).
  assign wr      = pending & ((count_q != FULL) | pop);

  // Occupancy after this edge, used to decide whether the ack can go out now.
  always_comb begin
    cnt_post = count_q;
    case ({wr, pop})
      2'b10:   cnt_post = count_q + CW'(1);
      2'b01:   cnt_post = count_q - CW'(1);
      default: cnt_post = count_q;
    endcase
  end

  // Datapath next-state: phase tracking, pointers and count.
  always_comb begin
    seen_d   = seen_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = cnt_post;
    if (wr) begin
      seen_d   = drive_s;
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
  end

  // Ack FSM: ack immediately unless this write filled the buffer; then hold
  // the ack until the first pop frees a slot.
  always_comb begin
    state_d = state_q;
    free_d  = free_q;
    case (state_q)
      IDLE: begin
        if (wr) begin
          if (cnt_post == FULL) state_d = HOLD;
          else                  free_d  = ~free_q;
        end
      end
      HOLD: begin
        if (pop) begin
          free_d  = ~free_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Synchronizer chain on the asynchronous drive toggle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], i_drive};
  end

  // Control state: phase, ack, FSM, pointers, occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seen_q   <= 1'b0;
      free_q   <= 1'b0;
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      seen_q   <= seen_d;
      free_q   <= free_d;
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; bundling guarantees i_data is stable once the token is seen,
  // so it is captured directly without its own synchronizer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    mem_q           <= '0;
    else if (wr) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_free  = free_q;
  assign o_valid = (count_q != '0);
  assign o_data  = mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

// File: tb/tb_click_sync_sink.sv
`timescale 1ns/1ps
// Bench for click_sync_sink: an upstream click-stage model issues tokens
// only after the previous ack; expected words go into a queue and a monitor
// compares every popped word against it.
module tb_click_sync_sink;
  localparam int DW = 8, DEPTH = 4, CW = $clog2(DEPTH) + 1;

  logic          clk = 0, rst = 0, i_drive = 0, i_ready = 0;
  logic [DW-1:0] i_data = '0;
  logic          o_free, o_valid;
  logic [DW-1:0] o_data;
  logic [CW-1:0] o_count;

  int            total = 0, bad = 0;
  logic [DW-1:0] expq[$];
  int            ftog = 0, npop = 0, nsent = 0;
  int            mode = 0;          // 0 forced, 1 alternate, 2 random
  logic          ready_force = 0;

  always #5 clk = ~clk;

  click_sync_sink #(.DW(DW), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .i_drive(i_drive), .i_data(i_data),
    .o_free(o_free), .o_valid(o_valid), .o_data(o_data),
    .i_ready(i_ready), .o_count(o_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Count ack toggles seen by upstream (reset-induced changes excluded).
  always @(o_free) if (rst) ftog++;

  // Downstream ready driver, updated just after each edge.
  always @(posedge clk) begin
    #1;
    case (mode)
      0:       i_ready = ready_force;
      1:       i_ready = ~i_ready;
      default: i_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: at the falling edge, a valid&ready pair means the next edge pops.
  always @(negedge clk) begin
    if (rst) begin
      chk("proto_full", (o_count <= DEPTH), 1);
      chk("valid_vs_count", o_valid, (o_count != 0));
      if (o_valid && i_ready) begin
        if (expq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_word actual=%0h expected=none t=%0t", o_data, $time);
        end else begin
          chk("order", o_data, expq.pop_front());
          npop++;
        end
      end
    end
  end

  task automatic wait_free();
    for (int k = 0; k < 5000 && o_free !== i_drive; k++) #1;
    chk("free_wait", (o_free === i_drive), 1);
  endtask

  task automatic send(input logic [DW-1:0] d);
    wait_free();
    @(posedge clk); #1;
    i_data  = d;
    i_drive = ~i_drive;
    expq.push_back(d);
    nsent++;
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic pop1();
    @(posedge clk); ready_force = 1;
    @(posedge clk); ready_force = 0;
    #2;
  endtask

  task automatic drain(input string nm);
    ready_force = 1;
    for (int k = 0; k < 200 && (o_count != 0 || expq.size() != 0); k++) @(posedge clk);
    #2;
    chk(nm, o_count, 0);
    ready_force = 0;
    clocks(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    // Reset state
    clocks(2); #2;
    chk("rst_valid", o_valid, 0);
    chk("rst_count", o_count, 0);
    chk("rst_free", o_free, 0);
    chk("rst_data", o_data, 0);
    rst = 1;
    clocks(2);

    // Single token, exact 3-edge latency
    @(posedge clk); #1;
    i_data = 8'hA5; i_drive = 1; expq.push_back(8'hA5); nsent++;
    clocks(2); #1;
    chk("lat_early_valid", o_valid, 0);
    @(posedge clk); #1;
    chk("single_valid", o_valid, 1);
    chk("single_data", o_data, 8'hA5);
    chk("single_count", o_count, 1);
    chk("single_free", o_free, 1);
    pop1();
    chk("single_pop_valid", o_valid, 0);
    chk("single_pop_count", o_count, 0);

    // Fill and stall
    f0 = ftog;
    for (int d = 1; d <= 4; d++) send(8'(d));
    clocks(6); #1;
    chk("fill_toggles", ftog - f0, 3);
    chk("fill_count", o_count, 4);
    pop1();
    chk("release_toggles", ftog - f0, 4);
    chk("release_count", o_count, 3);
    send(8'h05);
    clocks(5); #1;
    chk("fifth_count", o_count, 4);
    drain("fill_drain");

    // Wrap order with alternating ready
    mode = 1;
    for (int d = 8'h10; d <= 8'h19; d++) send(8'(d));
    for (int k = 0; k < 200 && expq.size() != 0; k++) @(posedge clk);
    mode = 0; ready_force = 0;
    clocks(3);
    chk("wrap_all_out", expq.size(), 0);
    chk("wrap_count", o_count, 0);

    // Simultaneous write and pop
    send(8'h20); send(8'h21);
    clocks(5); #1;
    chk("simul_pre_count", o_count, 2);
    f0 = ftog;
    send(8'h22);
    @(posedge clk);                    // E1
    @(posedge clk); ready_force = 1;   // E2
    @(posedge clk); ready_force = 0;   // E3: write and pop
    #1;
    chk("simul_count", o_count, 2);
    chk("simul_toggle", ftog - f0, 1);
    chk("simul_free", o_free, i_drive);
    drain("simul_drain");

    // Reset mid-operation from a full buffer holding its ack
    for (int d = 8'h30; d <= 8'h33; d++) send(8'(d));
    clocks(6); #1;
    chk("hold_count", o_count, 4);
    chk("hold_ack_withheld", (o_free !== i_drive), 1);
    #3;
    rst = 0; i_drive = 0;
    nsent -= expq.size();
    expq.delete();
    #1;
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_count", o_count, 0);
    chk("mid_rst_free", o_free, 0);
    chk("mid_rst_data", o_data, 0);
    @(negedge clk); #2;
    rst = 1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("post_rst_count", o_count, 0);
    end

    // Asynchronous jitter, random ready
    mode = 2;
    for (int n = 0; n < 200; n++) begin
      wait_free();
      #($urandom_range(1, 37));
      i_data  = 8'($urandom);
      i_drive = ~i_drive;
      expq.push_back(i_data);
      nsent++;
    end
    for (int k = 0; k < 500 && expq.size() != 0; k++) @(posedge clk);
    mode = 0; ready_force = 0;
    clocks(3);
    chk("jitter_all_out", expq.size(), 0);
    chk("jitter_count", o_count, 0);
    chk("jitter_free", o_free, i_drive);
    chk("received_total", npop, nsent);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
